// File: rtl/data_mem_unit.sv
// Load/store responder over a word-organised synchronous RAM.
// Handles byte/half lane placement, read-modify-write for sub-word stores and alignment checking.
module data_mem_unit #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  alu_control,
  input  logic [31:0] addr,
  input  logic [31:0] gen_purpose_reg_data_write,
  output logic        resp_valid,
  output logic [31:0] gen_purpose_reg_data_read,
  output logic        acc_err
);

  localparam logic [6:0] OP_LW = 7'd30, OP_LH = 7'd31, OP_LHU = 7'd32, OP_LB = 7'd33,
                         OP_LBU = 7'd34, OP_SW = 7'd35, OP_SH = 7'd36, OP_SB = 7'd37;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  typedef struct packed {
    logic [6:0]    op;
    logic [1:0]    off;
    logic [AW-1:0] widx;
    logic [31:0]   data;
    logic          err;
  } req_t;

  state_t      state, state_nxt;
  req_t        req;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rd_word, merged, sdata, ld_data;
  logic [3:0]  be;
  logic        bad, is_store;

  always_comb begin
    bad = !(alu_control inside {[OP_LW:OP_SB]});
    if ((alu_control == OP_LW || alu_control == OP_SW) && addr[1:0] != 2'b00)
      bad = 1'b1;
    if ((alu_control == OP_LH || alu_control == OP_LHU || alu_control == OP_SH) && addr[0])
      bad = 1'b1;
  end

  assign is_store = req.op inside {OP_SW, OP_SH, OP_SB};

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = bad ? RESP : READ;
      end
      READ:  state_nxt = is_store ? WRITE : RESP;
      WRITE: state_nxt = RESP;
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      req   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid)
        req <= '{op: alu_control, off: addr[1:0], widx: addr[AW+1:2],
                 data: gen_purpose_reg_data_write, err: bad};
    end
  end

  // RAM is deliberately left out of reset; writes only fire from WRITE, which reset abandons.
  always_ff @(posedge clk) begin
    if (state == READ) rd_word <= mem[req.widx];
    if (state == WRITE && rst_n) mem[req.widx] <= merged;
  end

  always_comb begin
    be    = 4'h0;
    sdata = req.data;
    case (req.op)
      OP_SW: be = 4'hF;
      OP_SH: begin
        be    = req.off[1] ? 4'hC : 4'h3;
        sdata = {2{req.data[15:0]}};
      end
      OP_SB: begin
        be    = 4'b0001 << req.off;
        sdata = {4{req.data[7:0]}};
      end
      default: be = 4'h0;
    endcase
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign merged[8*i +: 8] = be[i] ? sdata[8*i +: 8] : rd_word[8*i +: 8];
  end

  // Half offsets are even, so a byte-granular shift serves both widths.
  always_comb begin
    logic [31:0] shifted;
    shifted = rd_word >> {req.off, 3'b000};
    ld_data = '0;
    case (req.op)
      OP_LW:         ld_data = rd_word;
      OP_LH, OP_LHU: ld_data = {16'h0, shifted[15:0]};
      OP_LB, OP_LBU: ld_data = {24'h0, shifted[7:0]};
      default:       ld_data = '0;
    endcase
  end

  assign gen_purpose_reg_data_read = (resp_valid && !req.err) ? ld_data : 32'h0;
  assign acc_err                   = resp_valid && req.err;

endmodule

// File: tb/tb_data_mem_unit.sv
// Bench for data_mem_unit: byte-addressed reference memory, directed plan cases and random traffic.
module tb_data_mem_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [6:0]  alu_control = '0;
  logic [31:0] addr = '0;
  logic [31:0] gen_purpose_reg_data_write = '0;
  logic        resp_valid;
  logic [31:0] gen_purpose_reg_data_read;
  logic        acc_err;

  int checks = 0;
  int errors = 0;
  logic [7:0] mmem [1024];

  always #5 clk = ~clk;

  data_mem_unit #(.DEPTH_WORDS(256), .AW(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .alu_control(alu_control), .addr(addr),
    .gen_purpose_reg_data_write(gen_purpose_reg_data_write),
    .resp_valid(resp_valid), .gen_purpose_reg_data_read(gen_purpose_reg_data_read),
    .acc_err(acc_err)
  );

  // Reference: byte-addressed memory of 1024 bytes, access size and alignment from the opcode.
  task automatic model(input logic [6:0] op, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] ed, output logic ee, output int el);
    int sz;
    int b;
    bit st;
    ed = '0;
    ee = 1'b0;
    case (op)
      7'd30, 7'd35:        sz = 4;
      7'd31, 7'd32, 7'd36: sz = 2;
      7'd33, 7'd34, 7'd37: sz = 1;
      default:             sz = 0;
    endcase
    st = (op >= 7'd35 && op <= 7'd37);
    if (sz == 0 || (int'(a[1:0]) % sz) != 0) begin
      ee = 1'b1;
      el = 1;
      return;
    end
    b = int'(a[9:0]);
    for (int k = 0; k < sz; k++) begin
      if (st) mmem[b+k] = d[8*k +: 8];
      else    ed[8*k +: 8] = mmem[b+k];
    end
    el = st ? 3 : 2;
  endtask

  task automatic access(input string nm, input logic [6:0] op, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] got);
    logic [31:0] ed;
    logic        ee, gerr;
    int          el, lat;
    model(op, a, d, ed, ee, el);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready: got %b want 1", nm, req_ready);
    end
    alu_control = op;
    addr = a;
    gen_purpose_reg_data_write = d;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    got = '0;
    gerr = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        lat = i;
        got = gen_purpose_reg_data_read;
        gerr = acc_err;
        break;
      end
    end
    checks++;
    if (lat != el) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d (op %0d addr %h)", nm, lat, el, op, a);
    end
    checks++;
    if (got !== ed) begin
      errors++;
      $display("FAIL %s data: got %h want %h (op %0d addr %h)", nm, got, ed, op, a);
    end
    checks++;
    if (gerr !== ee) begin
      errors++;
      $display("FAIL %s acc_err: got %b want %b (op %0d addr %h)", nm, gerr, ee, op, a);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || gen_purpose_reg_data_read !== 32'h0 || acc_err !== 1'b0) begin
      errors++;
      $display("FAIL %s after_resp: valid %b data %h err %b want 0 0 0", nm,
               resp_valid, gen_purpose_reg_data_read, acc_err);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || acc_err !== 1'b0 ||
        gen_purpose_reg_data_read !== 32'h0) begin
      errors++;
      $display("FAIL reset: ready %b valid %b err %b data %h want 1 0 0 0",
               req_ready, resp_valid, acc_err, gen_purpose_reg_data_read);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    logic [31:0] g;
    for (int w = 0; w < 256; w++) access("fill", 7'd35, 32'(w * 4), 32'h0, g);
  endtask

  task automatic test_directed();
    logic [31:0] g;
    access("sw_word", 7'd35, 32'h10, 32'hDEADBEEF, g);
    access("lw_word", 7'd30, 32'h10, 32'h0, g);
    checks++;
    if (g !== 32'hDEADBEEF) begin errors++; $display("FAIL round_trip: got %h want deadbeef", g); end
    access("pre", 7'd35, 32'h20, 32'h11223344, g);
    access("sb", 7'd37, 32'h21, 32'h000000AA, g);
    access("sh", 7'd36, 32'h22, 32'h0000BBCC, g);
    access("lw_merge", 7'd30, 32'h20, 32'h0, g);
    checks++;
    if (g !== 32'hBBCCAA44) begin errors++; $display("FAIL merge: got %h want bbccaa44", g); end
    access("lane_pre", 7'd35, 32'h30, 32'h80FF7F01, g);
    access("lb", 7'd33, 32'h31, 32'h0, g);
    checks++;
    if (g !== 32'h0000007F) begin errors++; $display("FAIL lb: got %h want 0000007f", g); end
    access("lbu", 7'd34, 32'h33, 32'h0, g);
    checks++;
    if (g !== 32'h00000080) begin errors++; $display("FAIL lbu: got %h want 00000080", g); end
    access("lh", 7'd31, 32'h32, 32'h0, g);
    checks++;
    if (g !== 32'h000080FF) begin errors++; $display("FAIL lh: got %h want 000080ff", g); end
    access("lw_mis", 7'd30, 32'h02, 32'h0, g);
    access("sh_mis", 7'd36, 32'h05, 32'h0000FFFF, g);
    access("lw_chk", 7'd30, 32'h04, 32'h0, g);
    checks++;
    if (g !== 32'h0) begin errors++; $display("FAIL sh_mis_ram: got %h want 0", g); end
    access("illegal", 7'd12, 32'h00, 32'h0, g);
    access("sw_wrap", 7'd35, 32'h400, 32'hCAFEF00D, g);
    access("lw_wrap", 7'd30, 32'h000, 32'h0, g);
    checks++;
    if (g !== 32'hCAFEF00D) begin errors++; $display("FAIL wrap: got %h want cafef00d", g); end
  endtask

  task automatic test_handshake();
    logic [31:0] ed;
    logic        ee;
    int          el, pulses;
    model(7'd30, 32'h30, 32'h0, ed, ee, el);
    @(negedge clk);
    alu_control = 7'd30;
    addr = 32'h30;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL hs_busy1: got %b want 0", req_ready); end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b1 || gen_purpose_reg_data_read !== ed) begin
      errors++;
      $display("FAIL hs_resp: ready %b valid %b data %h want 0 1 %h",
               req_ready, resp_valid, gen_purpose_reg_data_read, ed);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL hs_single: extra pulses %0d ready %b want 0 1", pulses, req_ready);
    end
  endtask

  task automatic test_reset_mid_store();
    logic [31:0] g;
    int pulses;
    @(negedge clk);
    alu_control = 7'd35;
    addr = 32'h40;
    gen_purpose_reg_data_write = 32'h12345678;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (resp_valid !== 1'b0 || gen_purpose_reg_data_read !== 32'h0 || acc_err !== 1'b0 ||
        req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid: valid %b data %h err %b ready %b want 0 0 0 1",
               resp_valid, gen_purpose_reg_data_read, acc_err, req_ready);
    end
    pulses = 0;
    repeat (2) begin
      @(negedge clk);
      if (resp_valid === 1'b1) pulses++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL rst_noresp: pulses %0d want 0", pulses); end
    access("rst_lw", 7'd30, 32'h40, 32'h0, g);
    checks++;
    if (g !== 32'h0) begin errors++; $display("FAIL rst_ram: got %h want 0", g); end
  endtask

  task automatic test_random();
    logic [31:0] g, a;
    logic [6:0]  op;
    for (int n = 0; n < 300; n++) begin
      op = 7'($urandom_range(28, 39));
      a  = {$urandom_range(0, 15) == 0 ? $urandom() : 32'h0} & 32'hFFFF_FC00;
      a  = a | 32'($urandom_range(0, 63));
      access("rand", op, a, $urandom(), g);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mmem[i] = 8'h0;
    test_reset();
    test_fill();
    test_directed();
    test_handshake();
    test_reset_mid_store();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
